interp_point_gen: RTL and testbench



---
 rtl/interp_point_gen.sv | 104 ++++++++++
 tb/tb_interp_point_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/interp_point_gen.sv
// interp_point_gen: emits six interpolated points base+k*E (k=0..5) over a valid/ready handshake; INTERP_SAT_EN selects saturation instead of wrap on narrowing
module interp_point_gen #(
    parameter int IN_W  = 16,
    parameter int REG1  = 17,
    parameter int REG2  = 18,
    parameter int REG3  = 19,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  base_in,
    input  logic signed [REG1-1:0]  reg_E,
    input  logic signed [REG2-1:0]  reg_2E,
    input  logic signed [REG3-1:0]  reg_5E,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic [2:0]              out_idx,
    output logic                    out_last,
    output logic                    busy,
    output logic                    start_err
);
    localparam int ACC_W = REG3 + 2;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                  r_state, w_state_nxt;
    logic signed [IN_W-1:0]  r_base;
    logic signed [REG1-1:0]  r_e;
    logic signed [REG2-1:0]  r_2e;
    logic signed [REG3-1:0]  r_5e;
    logic [OUT_W-1:0]        r_data;
    logic [2:0]              r_idx;
    logic                    r_valid, r_err;
    logic                    w_hs, w_end, w_accept, w_adv;
    logic [2:0]              w_k;
    logic signed [ACC_W-1:0] w_b, w_x, w_y, w_sum;
    logic [OUT_W-1:0]        w_res;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // next state, handshake decode and point arithmetic (base + x + y, two adders)
    always_comb begin
        w_hs        = r_valid && out_ready;
        w_end       = w_hs && (r_idx == 3'd5);
        w_accept    = start && (r_state == IDLE || w_end);
        w_adv       = w_hs && (r_idx != 3'd5);
        w_state_nxt = w_accept ? EMIT : w_end ? IDLE : r_state;
        w_k         = w_accept ? 3'd0 : r_idx + 3'd1;
        w_b         = w_accept ? ACC_W'(base_in) : ACC_W'(r_base);
        w_x         = (w_k == 3'd1 || w_k == 3'd3) ? ACC_W'(r_e) :
                      (w_k == 3'd2 || w_k == 3'd4) ? ACC_W'(r_2e) :
                      (w_k == 3'd5) ? ACC_W'(r_5e) : '0;
        w_y         = (w_k == 3'd3 || w_k == 3'd4) ? ACC_W'(r_2e) : '0;
        w_sum       = w_b + w_x + w_y;
`ifdef INTERP_SAT_EN
        w_res       = (w_sum > MAXV) ? MAXV[OUT_W-1:0] :
                      (w_sum < MINV) ? MINV[OUT_W-1:0] : w_sum[OUT_W-1:0];
`else
        w_res       = w_sum[OUT_W-1:0];
`endif
    end

    // operand capture and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base  <= '0;
            r_e     <= '0;
            r_2e    <= '0;
            r_5e    <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base <= base_in;
                r_e    <= reg_E;
                r_2e   <= reg_2E;
                r_5e   <= reg_5E;
            end
            if (w_accept || w_adv) begin
                r_data <= w_res;
                r_idx  <= w_k;
            end
            r_valid <= w_accept || (r_valid && !w_end);
            r_err   <= start && (r_state == EMIT) && !w_accept;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_valid && (r_idx == 3'd5);
    assign busy      = (r_state == EMIT);
    assign start_err = r_err;
endmodule

// File: tb/tb_interp_point_gen.sv
// tb_interp_point_gen: directed checks of interp_point_gen sequences, backpressure, start handling, overflow and reset
module tb_interp_point_gen;
    logic              clk = 1'b0;
    logic              rst, start, out_ready;
    logic signed [15:0] base_in;
    logic signed [16:0] reg_E;
    logic signed [17:0] reg_2E;
    logic signed [18:0] reg_5E;
    logic              out_valid, out_last, busy, start_err;
    logic [15:0]       out_data;
    logic [2:0]        out_idx;
    int                n_chk = 0, n_err = 0;
    int                ev[6];

    interp_point_gen dut (
        .clk(clk), .rst(rst), .start(start), .base_in(base_in), .reg_E(reg_E),
        .reg_2E(reg_2E), .reg_5E(reg_5E), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy),
        .start_err(start_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int b, input int e, input int e2, input int e5);
        base_in = 16'(b);
        reg_E   = 17'(e);
        reg_2E  = 18'(e2);
        reg_5E  = 19'(e5);
    endtask

    task automatic go(input int b, input int e, input int e2, input int e5);
        set_in(b, e, e2, e5);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_in(0, 0, 0, 0);
    endtask

    task automatic pt(input string tag, input int k);
        chk({tag, ".valid"}, int'(out_valid), 1);
        chk({tag, ".idx"}, int'(out_idx), k);
        chk({tag, ".data"}, int'($signed(out_data)), ev[k]);
        chk({tag, ".last"}, int'(out_last), int'(k == 5));
        chk({tag, ".busy"}, int'(busy), 1);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pt(tag, k);
            tick();
        end
        chk({tag, ".end_valid"}, int'(out_valid), 0);
        chk({tag, ".end_busy"}, int'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        set_in(0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        chk("rst.valid", int'(out_valid), 0);
        chk("rst.data", int'(out_data), 0);
        chk("rst.idx", int'(out_idx), 0);
        chk("rst.last", int'(out_last), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.err", int'(start_err), 0);

        ev = '{100, 110, 120, 130, 140, 150};
        go(100, 10, 20, 50);
        drain("basic");

        ev = '{-200, -207, -214, -221, -228, -235};
        go(-200, -7, -14, -35);
        drain("neg");

        ev = '{100, 110, 120, 130, 140, 150};
        go(100, 10, 20, 50);
        pt("bp", 0); tick();
        pt("bp", 1); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pt("bp.stall", 2);
            tick();
        end
        out_ready = 1'b1;
        pt("bp.resume", 2); tick();
        pt("bp", 3); tick();
        pt("bp", 4); tick();
        pt("bp", 5); tick();
        chk("bp.end_valid", int'(out_valid), 0);

`ifdef INTERP_SAT_EN
        ev = '{32000, 32500, 32767, 32767, 32767, 32767};
`else
        ev = '{32000, 32500, -32536, -32036, -31536, -31036};
`endif
        go(32000, 500, 1000, 2500);
        drain("ovf");

        ev = '{100, 110, 120, 130, 140, 150};
        go(100, 10, 20, 50);
        for (int k = 0; k < 3; k++) begin
            pt("sidx3", k);
            tick();
        end
        pt("sidx3", 3);
        set_in(7, 7, 7, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sidx3.err", int'(start_err), 1);
        pt("sidx3", 4);
        tick();
        chk("sidx3.err_clr", int'(start_err), 0);
        pt("sidx3", 5);
        set_in(0, 1, 2, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b.err", int'(start_err), 0);
        ev = '{0, 1, 2, 3, 4, 5};
        drain("b2b");

        ev = '{100, 110, 120, 130, 140, 150};
        go(100, 10, 20, 50);
        tick(); tick();
        chk("rmid.idx_pre", int'(out_idx), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid.valid", int'(out_valid), 0);
        chk("rmid.data", int'(out_data), 0);
        chk("rmid.idx", int'(out_idx), 0);
        chk("rmid.last", int'(out_last), 0);
        chk("rmid.busy", int'(busy), 0);
        chk("rmid.err", int'(start_err), 0);
        tick();
        chk("rmid.idle_valid", int'(out_valid), 0);
        go(100, 10, 20, 50);
        drain("rmid.fresh");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
